// File: rtl/oled_serial_receiver.sv
// oled_serial_receiver: AHB-Lite slave that captures bytes from a 4-wire
// OLED-style serial interface (nCS, DnC, SDIN, SCLK) into a receive FIFO.
// Optional build macro OLED_RX_IRQ_EN adds the IRQ output and CTRL.irq_en.
module oled_serial_receiver #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        nCS,
    input  logic        DnC,
    input  logic        SDIN,
    input  logic        SCLK
`ifdef OLED_RX_IRQ_EN
    ,
    output logic        IRQ
`endif
);

    localparam int unsigned PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH5 = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ADDR_RXDATA = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_RSVD   = 2'd3
    } reg_addr_e;

    // Registered AHB address phase
    reg_addr_e       addr_q;
    logic            wr_q;
    logic            act_q;

    // Input synchronizers
    logic            ncs_meta_q, ncs_s_q;
    logic            dnc_meta_q, dnc_s_q;
    logic            sdin_meta_q, sdin_s_q;
    logic            sclk_meta_q, sclk_s_q, sclk_prev_q;

    // Receive datapath and FIFO state
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [4:0]      count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            enable_q, enable_d;
    logic [8:0]      mem_q [FIFO_DEPTH];

    logic            irq_en_rd;
`ifdef OLED_RX_IRQ_EN
    logic            irq_en_q, irq_en_d;
    logic            irq_q;
`endif

    logic            rd_phase, wr_phase, ctrl_wr, flush;
    logic            empty, full, pop, push_req, push, sclk_rise;
    logic [8:0]      push_data;

    logic            unused_ok;
    assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:2]};

    assign HREADYOUT = 1'b1;

    // Capture AHB address phase for action in the following data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= ADDR_RXDATA;
            wr_q   <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            act_q <= HSEL && HREADY && HTRANS[1];
            if (HSEL && HREADY && HTRANS[1]) begin
                addr_q <= reg_addr_e'(HADDR[3:2]);
                wr_q   <= HWRITE;
            end
        end
    end

    // Two-flop synchronizers for the serial pins plus SCLK history for edge detect
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ncs_meta_q  <= 1'b1;
            ncs_s_q     <= 1'b1;
            dnc_meta_q  <= 1'b0;
            dnc_s_q     <= 1'b0;
            sdin_meta_q <= 1'b0;
            sdin_s_q    <= 1'b0;
            sclk_meta_q <= 1'b0;
            sclk_s_q    <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            ncs_meta_q  <= nCS;
            ncs_s_q     <= ncs_meta_q;
            dnc_meta_q  <= DnC;
            dnc_s_q     <= dnc_meta_q;
            sdin_meta_q <= SDIN;
            sdin_s_q    <= sdin_meta_q;
            sclk_meta_q <= SCLK;
            sclk_s_q    <= sclk_meta_q;
            sclk_prev_q <= sclk_s_q;
        end
    end

    // Next-state logic: bit shifting, FIFO push/pop/flush, control register
    always_comb begin
        rd_phase  = act_q && !wr_q;
        wr_phase  = act_q && wr_q;
        empty     = (count_q == 5'd0);
        full      = (count_q == DEPTH5);
        sclk_rise = sclk_s_q && !sclk_prev_q;
        ctrl_wr   = wr_phase && (addr_q == ADDR_CTRL);
        flush     = ctrl_wr && HWDATA[1];
        pop       = rd_phase && (addr_q == ADDR_RXDATA) && !empty;

        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        push_req  = 1'b0;
        if (!enable_q || ncs_s_q) begin
            shift_d  = '0;
            bitcnt_d = '0;
        end else if (sclk_rise) begin
            shift_d  = {shift_q[6:0], sdin_s_q};
            bitcnt_d = bitcnt_q + 3'd1;
            push_req = (bitcnt_q == 3'd7);
        end
        push_data = {dnc_s_q, shift_d};

        // A full FIFO still accepts a push when a pop frees a slot this cycle
        push  = push_req && (!full || pop) && !flush;
        ovf_d = ovf_q;
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end

        wptr_d  = push ? (wptr_q + PW'(1)) : wptr_q;
        rptr_d  = pop  ? (rptr_q + PW'(1)) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 5'd1;
        end else if (pop && !push) begin
            count_d = count_q - 5'd1;
        end

        enable_d = ctrl_wr ? HWDATA[0] : enable_q;
`ifdef OLED_RX_IRQ_EN
        irq_en_d = ctrl_wr ? HWDATA[2] : irq_en_q;
`endif

        if (flush) begin
            wptr_d   = '0;
            rptr_d   = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            bitcnt_d = '0;
            shift_d  = '0;
        end
    end

    // State registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            enable_q <= 1'b0;
`ifdef OLED_RX_IRQ_EN
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
`endif
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            enable_q <= enable_d;
`ifdef OLED_RX_IRQ_EN
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q && (!empty || ovf_q);
`endif
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

`ifdef OLED_RX_IRQ_EN
    assign irq_en_rd = irq_en_q;
    assign IRQ       = irq_q;
`else
    assign irq_en_rd = 1'b0;
`endif

    // Read data mux, driven only during a registered read data phase
    always_comb begin
        HRDATA = '0;
        if (rd_phase) begin
            unique case (addr_q)
                ADDR_RXDATA: HRDATA = empty ? 32'd0 : {23'd0, mem_q[rptr_q]};
                ADDR_STATUS: HRDATA = {24'd0, count_q, ovf_q, full, empty};
                ADDR_CTRL:   HRDATA = {29'd0, irq_en_rd, 1'b0, enable_q};
                default:     HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_serial_receiver.sv
// Directed self-checking bench for oled_serial_receiver (FIFO_DEPTH=8).
module tb_oled_serial_receiver;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [2:0]  HSIZE = 3'd2;
    logic [1:0]  HTRANS = 2'd0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        nCS = 1'b1, DnC = 1'b0, SDIN = 1'b0, SCLK = 1'b0;
`ifdef OLED_RX_IRQ_EN
    logic        IRQ;
`endif

    int unsigned vectors = 0;
    int unsigned fails   = 0;
    logic [31:0] rd;

    oled_serial_receiver #(.FIFO_DEPTH(8)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .nCS       (nCS),
        .DnC       (DnC),
        .SDIN      (SDIN),
        .SCLK      (SCLK)
`ifdef OLED_RX_IRQ_EN
        ,
        .IRQ       (IRQ)
`endif
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    // Address phase on one edge, data phase sampled on the following negedge
    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
        @(posedge HCLK);
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        @(posedge HCLK);
    endtask

    // SDIN set while SCLK low, then SCLK high; 4 HCLK per phase
    task automatic send_bit(input logic b);
        @(negedge HCLK);
        SCLK = 1'b0; SDIN = b;
        cycles(4);
        SCLK = 1'b1;
        cycles(4);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        cycles(2);
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(addr, d);
        check(tag, d, exp);
    endtask

    initial begin
        // Reset state
        cycles(3);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'h1);
`ifdef OLED_RX_IRQ_EN
        check("rst_irq", {31'd0, IRQ}, 32'h0);
`endif
        HRESETn = 1'b1;
        cycles(2);
        read_check("rst_status", 32'h4, 32'h01);
        read_check("rst_ctrl",   32'h8, 32'h0);
        read_check("rst_rx_empty", 32'h0, 32'h0);

        // Single data byte 0xA5
        ahb_write(32'h8, 32'h1);
        read_check("ctrl_en", 32'h8, 32'h1);
        nCS = 1'b0; DnC = 1'b1;
        cycles(4);
        send_byte(8'hA5);
        read_check("a5_status", 32'h4, 32'h08);
        read_check("a5_rx",     32'h0, 32'h1A5);
        read_check("a5_empty",  32'h4, 32'h01);

        // Two command bytes in order
        DnC = 1'b0;
        send_byte(8'h3C);
        send_byte(8'h81);
        read_check("cmd_status", 32'h4, 32'h10);
        read_check("cmd_rx0",    32'h0, 32'h03C);
        read_check("cmd_rx1",    32'h0, 32'h081);
        read_check("cmd_empty",  32'h4, 32'h01);

        // Overflow: 9 bytes into 8 entries
        DnC = 1'b1;
        for (int b = 0; b < 9; b++) send_byte(8'(b));
        read_check("ovf_status", 32'h4, 32'h46);
        for (int b = 0; b < 8; b++) read_check("ovf_rx", 32'h0, 32'h100 + 32'(b));
        read_check("ovf_sticky", 32'h4, 32'h05);
        read_check("ovf_rx_empty", 32'h0, 32'h0);
        read_check("ovf_sticky2", 32'h4, 32'h05);
        ahb_write(32'h8, 32'h3);
        read_check("flush_ctrl",   32'h8, 32'h1);
        read_check("flush_status", 32'h4, 32'h01);

        // Partial byte discarded by nCS
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        nCS = 1'b1;
        cycles(4);
        nCS = 1'b0;
        cycles(4);
        send_byte(8'h55);
        read_check("part_status", 32'h4, 32'h08);
        read_check("part_rx",     32'h0, 32'h155);
        read_check("part_empty",  32'h4, 32'h01);

        // Flush with 3 bytes queued
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        read_check("q3_status", 32'h4, 32'h18);
        ahb_write(32'h8, 32'h3);
        read_check("fl_status", 32'h4, 32'h01);
        read_check("fl_rx",     32'h0, 32'h0);

        // Receiver disabled ignores traffic
        ahb_write(32'h8, 32'h0);
        send_byte(8'h77);
        read_check("dis_status", 32'h4, 32'h01);

`ifdef OLED_RX_IRQ_EN
        // Interrupt follows FIFO non-empty
        ahb_write(32'h8, 32'h5);
        read_check("irq_ctrl", 32'h8, 32'h5);
        cycles(2);
        check("irq_idle", {31'd0, IRQ}, 32'h0);
        send_byte(8'h9E);
        check("irq_set", {31'd0, IRQ}, 32'h1);
        read_check("irq_rx", 32'h0, 32'h19E);
        cycles(2);
        check("irq_clr", {31'd0, IRQ}, 32'h0);
        ahb_write(32'h8, 32'h0);
`else
        // CTRL bit 2 writes are ignored and read back as 0
        ahb_write(32'h8, 32'h5);
        read_check("ctrl_bit2", 32'h8, 32'h1);
        ahb_write(32'h8, 32'h0);
`endif

        // Reset in the middle of a byte
        ahb_write(32'h8, 32'h1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge HCLK);
        HRESETn = 1'b0;
        cycles(2);
        check("mid_rst_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        cycles(2);
        read_check("mid_rst_ctrl",   32'h8, 32'h0);
        read_check("mid_rst_status", 32'h4, 32'h01);
        ahb_write(32'h8, 32'h1);
        DnC = 1'b0;
        cycles(4);
        send_byte(8'hC3);
        read_check("mid_rst_status2", 32'h4, 32'h08);
        read_check("mid_rst_rx",      32'h0, 32'h0C3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
